// File: rtl/cct_update_scheduler_if.sv
// Scheduler-facing bundle: ALS samples in, converter handshake, committed white point out.
// No backpressure anywhere; every strobe is a single-cycle pulse.
interface cct_update_scheduler_if;
    logic [15:0] als_cct;
    logic        als_valid;
    logic        frame_sync;
    logic        err_clr;
    logic [15:0] conv_cct;
    logic        conv_start;
    logic [95:0] conv_xyz;
    logic        conv_xyz_valid;
    logic [95:0] xyz_out;
    logic        xyz_update;
    logic        busy;
    logic        timeout_err;
    logic        err_sticky;

    // scheduler side
    modport slave (
        input  als_cct, als_valid, frame_sync, err_clr, conv_xyz, conv_xyz_valid,
        output conv_cct, conv_start, xyz_out, xyz_update, busy, timeout_err, err_sticky
    );

    // sensor / converter / video-timing side
    modport master (
        output als_cct, als_valid, frame_sync, err_clr, conv_xyz, conv_xyz_valid,
        input  conv_cct, conv_start, xyz_out, xyz_update, busy, timeout_err, err_sticky
    );
endinterface

// File: rtl/cct_update_scheduler.sv
// Filters CCT samples and runs one supervised conversion at a time; commits XYZ on frame_sync.
// conv_start 2 cycles after a qualifying sample; xyz_update 1 cycle after frame_sync; no backpressure.
module cct_update_scheduler #(
    parameter int HYST_K       = 100,
    parameter int MIN_INTERVAL = 1024,
    parameter int TIMEOUT      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cct_update_scheduler_if.slave  bus
);
    localparam int CD_W = $clog2(MIN_INTERVAL + 1);
    localparam int WT_W = $clog2(TIMEOUT + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MIN_INTERVAL);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT - 1);
    localparam logic [15:0]     HYST    = 16'(HYST_K);
    localparam logic [95:0]     XYZ_D65 = {32'h000116BD, 32'h00010000, 32'h0000F352};

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

    state_t          state;
    logic [15:0]     pending;
    logic            pending_full;
    logic [15:0]     last_cct;
    logic            have_ref;
    logic [CD_W-1:0] cooldown;
    logic [WT_W-1:0] wait_cnt;
    logic [95:0]     shadow;

    logic [15:0]     cct_diff;
    logic            hyst_ok;
    logic            take_pending;

    always_comb begin
        cct_diff     = (pending >= last_cct) ? (pending - last_cct) : (last_cct - pending);
        hyst_ok      = !have_ref || (cct_diff >= HYST);
        take_pending = (state == IDLE) && pending_full && (cooldown == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pending         <= '0;
            pending_full    <= 1'b0;
            last_cct        <= '0;
            have_ref        <= 1'b0;
            cooldown        <= '0;
            wait_cnt        <= '0;
            shadow          <= '0;
            bus.conv_cct    <= '0;
            bus.conv_start  <= 1'b0;
            bus.xyz_out     <= XYZ_D65;
            bus.xyz_update  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.err_sticky  <= 1'b0;
        end else begin
            bus.conv_start  <= 1'b0;
            bus.xyz_update  <= 1'b0;
            bus.timeout_err <= 1'b0;

            if (cooldown != '0)
                cooldown <= cooldown - 1'b1;

            // A fresh sample always lands, even in the cycle the old one is consumed.
            if (bus.als_valid) begin
                pending      <= bus.als_cct;
                pending_full <= 1'b1;
            end else if (take_pending) begin
                pending_full <= 1'b0;
            end

            // A timeout below overrides this clear.
            if (bus.err_clr)
                bus.err_sticky <= 1'b0;

            case (state)
                IDLE: begin
                    if (take_pending && hyst_ok) begin
                        bus.conv_cct   <= pending;
                        bus.conv_start <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= WAIT;
                        bus.busy       <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (bus.conv_xyz_valid) begin
                        shadow <= bus.conv_xyz;
                        state  <= COMMIT;
                    end else if (wait_cnt == WT_LAST) begin
                        bus.timeout_err <= 1'b1;
                        bus.err_sticky  <= 1'b1;
                        cooldown        <= CD_LOAD;
                        state           <= IDLE;
                        bus.busy        <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (bus.frame_sync) begin
                        bus.xyz_out    <= shadow;
                        bus.xyz_update <= 1'b1;
                        last_cct       <= bus.conv_cct;
                        have_ref       <= 1'b1;
                        cooldown       <= CD_LOAD;
                        state          <= IDLE;
                        bus.busy       <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cct_update_scheduler.sv
// Directed stimulus with a cycle-stamped scoreboard; a negedge monitor checks every output strobe.
module tb_cct_update_scheduler;
    localparam logic [95:0] D65  = {32'h000116BD, 32'h00010000, 32'h0000F352};
    localparam logic [95:0] R1   = {32'h00012000, 32'h00010000, 32'h0000E000};
    localparam logic [95:0] R2   = {32'h00011111, 32'h00010000, 32'h0000D222};
    localparam logic [95:0] R3   = {32'h0000C333, 32'h00010000, 32'h00014444};
    localparam logic [95:0] R4   = {32'h0000ABCD, 32'h00010000, 32'h0000DCBA};
    localparam logic [95:0] JUNK = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678};

    typedef struct {
        int          cyc;
        logic [95:0] dat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t start_q[$];
    exp_t upd_q[$];
    int   to_q[$];

    cct_update_scheduler_if bus();

    cct_update_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk_vec(string name, logic [95:0] act, logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void chk_int(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void unexpected(string name, int val);
        total++;
        bad++;
        $display("FAIL %s: got strobe (value %0d) at cycle %0d, required none", name, val, cyc);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    initial begin
        exp_t e;
        int   t;
        forever begin
            @(negedge clk);
            if (bus.conv_start) begin
                if (start_q.size() == 0) unexpected("conv_start", int'(bus.conv_cct));
                else begin
                    e = start_q.pop_front();
                    chk_int("conv_cct", int'(bus.conv_cct), int'(e.dat[15:0]));
                    chk_int("start_cycle", cyc, e.cyc);
                end
            end
            if (bus.xyz_update) begin
                if (upd_q.size() == 0) unexpected("xyz_update", 0);
                else begin
                    e = upd_q.pop_front();
                    chk_vec("xyz_out_at_update", bus.xyz_out, e.dat);
                    chk_int("update_cycle", cyc, e.cyc);
                end
            end
            if (bus.timeout_err) begin
                if (to_q.size() == 0) unexpected("timeout_err", 0);
                else begin
                    t = to_q.pop_front();
                    chk_int("timeout_cycle", cyc, t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_als(input logic [15:0] v, output int n);
        bus.als_cct   = v;
        bus.als_valid = 1'b1;
        n = cyc;
        tick();
        bus.als_valid = 1'b0;
    endtask

    task automatic respond(input int at, input logic [95:0] r, input logic with_fs);
        goto(at);
        bus.conv_xyz       = r;
        bus.conv_xyz_valid = 1'b1;
        bus.frame_sync     = with_fs;
        tick();
        bus.conv_xyz_valid = 1'b0;
        bus.frame_sync     = 1'b0;
    endtask

    task automatic frame_at(input int at);
        goto(at);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 3000; i++) begin
            if (bus.conv_start) begin
                s = cyc;
                break;
            end
            tick();
        end
        if (s < 0) chk_int("wait_start_bound", 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk_vec({tag, "_xyz_out"}, bus.xyz_out, D65);
        chk_int({tag, "_conv_cct"}, int'(bus.conv_cct), 0);
        chk_int({tag, "_conv_start"}, int'(bus.conv_start), 0);
        chk_int({tag, "_xyz_update"}, int'(bus.xyz_update), 0);
        chk_int({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
        chk_int({tag, "_err_sticky"}, int'(bus.err_sticky), 0);
        chk_int({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, s, u;
        bus.als_cct = '0;  bus.als_valid = 1'b0; bus.frame_sync = 1'b0;
        bus.err_clr = 1'b0; bus.conv_xyz = '0;   bus.conv_xyz_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(); tick();

        // First sample after reset converts unconditionally; idle frame_sync is ignored.
        chk_vec("post_reset_xyz", bus.xyz_out, D65);
        chk_int("post_reset_busy", int'(bus.busy), 0);
        frame_at(cyc);
        pulse_als(16'd6500, n);
        start_q.push_back('{n + 2, 96'd6500});
        wait_start(s);
        chk_int("busy_in_wait", int'(bus.busy), 1);

        // Result after 4 cycles, a stray result in COMMIT is ignored, commit on frame_sync.
        respond(s + 4, R1, 1'b0);
        respond(s + 8, JUNK, 1'b0);
        upd_q.push_back('{s + 15, R1});
        frame_at(s + 14);
        goto(s + 16);
        chk_vec("xyz_after_commit", bus.xyz_out, R1);
        chk_int("busy_after_commit", int'(bus.busy), 0);
        u = s + 15;

        // Hysteresis: 50 K away is dropped, 100 K away converts.
        goto(u + 1030);
        pulse_als(16'd6550, n);
        repeat (5) tick();
        chk_int("busy_after_hyst_drop", int'(bus.busy), 0);
        pulse_als(16'd6600, n);
        start_q.push_back('{n + 2, 96'd6600});
        wait_start(s);
        // Latest-wins: 5000 then 5200 arrive while busy; result lands on the timeout cycle and wins.
        pulse_als(16'd5000, n);
        respond(s + 15, R2, 1'b0);
        pulse_als(16'd5200, n);
        upd_q.push_back('{s + 26, R2});
        frame_at(s + 25);
        u = s + 26;

        // Only 5200 converts, exactly when cooldown expires; frame_sync with the capture does not commit.
        start_q.push_back('{u + 1025, 96'd5200});
        wait_start(s);
        respond(s + 4, R3, 1'b1);
        upd_q.push_back('{s + 11, R3});
        frame_at(s + 10);
        goto(s + 12);
        chk_vec("xyz_after_frame_skip", bus.xyz_out, R3);
        u = s + 11;

        // Silent converter: timeout, sticky error, white point held, err_clr clears.
        goto(u + 1030);
        pulse_als(16'd7000, n);
        start_q.push_back('{n + 2, 96'd7000});
        wait_start(s);
        to_q.push_back(s + 16);
        goto(s + 17);
        chk_int("err_sticky_set", int'(bus.err_sticky), 1);
        chk_vec("xyz_held_on_timeout", bus.xyz_out, R3);
        chk_int("busy_after_timeout", int'(bus.busy), 0);
        pulse_err_clr();
        chk_int("err_sticky_cleared", int'(bus.err_sticky), 0);

        // Timed-out 7000 did not become the reference, so 5250 is within hysteresis of 5200.
        goto(s + 16 + 1030);
        pulse_als(16'd5250, n);
        repeat (5) tick();
        chk_int("busy_ref_unchanged", int'(bus.busy), 0);

        // Timeout and err_clr in the same cycle leave the error set.
        pulse_als(16'd7500, n);
        start_q.push_back('{n + 2, 96'd7500});
        wait_start(s);
        to_q.push_back(s + 16);
        goto(s + 15);
        pulse_err_clr();
        chk_int("err_sticky_wins_over_clr", int'(bus.err_sticky), 1);
        pulse_err_clr();
        chk_int("err_sticky_cleared_again", int'(bus.err_sticky), 0);

        // Reset during WAIT, then a late result must not commit.
        goto(s + 16 + 1030);
        pulse_als(16'd6000, n);
        start_q.push_back('{n + 2, 96'd6000});
        wait_start(s);
        goto(s + 3);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        respond(cyc, R4, 1'b0);
        frame_at(cyc + 2);
        repeat (20) tick();
        chk_vec("xyz_after_late_result", bus.xyz_out, D65);
        chk_int("busy_after_late_result", int'(bus.busy), 0);

        chk_int("start_q_drained", start_q.size(), 0);
        chk_int("upd_q_drained", upd_q.size(), 0);
        chk_int("to_q_drained", to_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
